// File: rtl/fir_channel_scheduler.sv
// Serial MAC FIR engine time-shared across NUM_CH channels with per-channel
// delay lines, shared coefficients, round-robin input arbitration and a tagged result port.
module fir_channel_scheduler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned DW     = 16,
    parameter int unsigned CW     = 16,
    parameter int unsigned OW     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         s_valid,
    input  logic [NUM_CH*DW-1:0]      s_data,
    output logic [NUM_CH-1:0]         s_ready,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [CW-1:0]             coef_data,
    output logic                      m_valid,
    output logic [OW-1:0]             m_data,
    output logic [$clog2(NUM_CH)-1:0] m_ch,
    input  logic                      m_ready,
    output logic                      busy
);
    localparam int unsigned CHW = $clog2(NUM_CH);
    localparam int unsigned KW  = $clog2(TAPS);
    localparam int unsigned PW  = DW + CW;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                state;
    logic [CHW-1:0]        last_grant;
    logic [CHW-1:0]        ch_reg;
    logic [KW-1:0]         k;
    logic signed [OW-1:0]  acc;
    logic signed [CW-1:0]  coef [TAPS];
    logic signed [DW-1:0]  hist [NUM_CH][TAPS];

    logic                  grant_any;
    logic [CHW-1:0]        grant_idx;
    logic [CHW-1:0]        cand;
    logic signed [DW-1:0]  sample;
    logic signed [CW-1:0]  coef_sel;
    logic signed [DW-1:0]  hist_sel;
    logic signed [PW-1:0]  prod;
    logic signed [OW-1:0]  acc_next;

    // Round-robin search starting one past the last granted channel
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = last_grant + CHW'(i);
            if (!grant_any && s_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign s_ready = (state == IDLE && grant_any && !rst) ? (NUM_CH'(1) << grant_idx) : '0;
    assign busy    = (state != IDLE);
    assign sample  = s_data[32'(grant_idx)*DW +: DW];

    // Full-precision signed product, sign-extended into the accumulator
    assign coef_sel = coef[k];
    assign hist_sel = hist[ch_reg][k];
    assign prod     = PW'(coef_sel) * PW'(hist_sel);
    assign acc_next = acc + OW'(prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= CHW'(NUM_CH - 1);
            ch_reg     <= '0;
            k          <= '0;
            acc        <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_ch       <= '0;
            for (int unsigned t = 0; t < TAPS; t++) begin
                coef[t] <= '0;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    hist[c][t] <= '0;
                end
            end
        end else begin
            if (coef_we) begin
                coef[coef_addr] <= coef_data;
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        for (int unsigned t = TAPS - 1; t > 0; t--) begin
                            hist[grant_idx][t] <= hist[grant_idx][t-1];
                        end
                        hist[grant_idx][0] <= sample;
                        acc        <= '0;
                        k          <= '0;
                        ch_reg     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + KW'(1);
                    if (k == KW'(TAPS - 1)) begin
                        m_data  <= acc_next;
                        m_ch    <= ch_reg;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: a reference FIR model predicts each
// accepted sample's result, which is checked when the DUT presents it.
module tb_fir_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int TAPS   = 8;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int OW     = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_CH-1:0]     s_valid;
    logic [NUM_CH*DW-1:0]  s_data;
    logic [NUM_CH-1:0]     s_ready;
    logic                  coef_we;
    logic [2:0]            coef_addr;
    logic [CW-1:0]         coef_data;
    logic                  m_valid;
    logic [OW-1:0]         m_data;
    logic [1:0]            m_ch;
    logic                  m_ready;
    logic                  busy;

    fir_channel_scheduler #(.NUM_CH(NUM_CH), .TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .m_valid(m_valid), .m_data(m_data), .m_ch(m_ch), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     mh [NUM_CH][TAPS];
    int     mc [TAPS];
    longint exp_d[$];
    int     exp_c[$];
    longint out_d[$];
    int     out_c[$];
    int     grant_q[$];
    longint hs_t[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference FIR: shift the channel history, sum all taps, wrap to OW bits
    function automatic longint model_accept(input int ch, input int val);
        longint s;
        logic signed [OW-1:0] w;
        for (int t = TAPS - 1; t > 0; t--) mh[ch][t] = mh[ch][t-1];
        mh[ch][0] = val;
        s = 0;
        for (int t = 0; t < TAPS; t++) s += longint'(mc[t]) * longint'(mh[ch][t]);
        w = OW'(s);
        return longint'(w);
    endfunction

    // Mid-cycle monitor: predicts on input handshakes, checks on output handshakes
    always @(negedge clk) begin
        longint ed;
        int     ec;
        if (rst) begin
            exp_d.delete();
            exp_c.delete();
            for (int t = 0; t < TAPS; t++) begin
                mc[t] = 0;
                for (int c = 0; c < NUM_CH; c++) mh[c][t] = 0;
            end
        end else begin
            if (m_valid && m_ready) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    ed = exp_d.pop_front();
                    ec = exp_c.pop_front();
                    check("m_data", longint'($signed(m_data)), ed);
                    check("m_ch", longint'(m_ch), longint'(ec));
                    out_d.push_back(longint'($signed(m_data)));
                    out_c.push_back(int'(m_ch));
                end
            end
            if (coef_we) mc[coef_addr] = int'($signed(coef_data));
            if (s_ready != '0)
                check("s_ready_onehot_valid", longint'($onehot(s_ready) && ((s_ready & s_valid) == s_ready)), 1);
            for (int g = 0; g < NUM_CH; g++) begin
                if (s_valid[g] && s_ready[g]) begin
                    grant_q.push_back(g);
                    hs_t.push_back(longint'($time));
                    exp_d.push_back(model_accept(g, int'($signed(s_data[g*DW +: DW]))));
                    exp_c.push_back(g);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = CW'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic load_box();
        for (int i = 0; i < TAPS; i++) write_coef(i, (i < 4) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input int val);
        int n;
        n = 0;
        s_valid[ch] = 1'b1;
        s_data[ch*DW +: DW] = DW'(val);
        #1;
        while (!s_ready[ch] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_timeout", n, 0);
        tick();
        s_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_d.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        check("drain_pending", exp_d.size(), 0);
    endtask

    function automatic longint at_d(input int i);
        return (i < out_d.size()) ? out_d[i] : -999;
    endfunction

    function automatic int at_c(input int i);
        return (i < out_c.size()) ? out_c[i] : -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        longint t1 [5] = '{10, 30, 60, 100, 140};
        int     g3 [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; s_valid = '0; s_data = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; m_ready = 1'b1;
        tick();
        tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_ch", m_ch, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Moving-sum coefficients on channel 0, with latency and throughput
        load_box();
        out_d.delete(); hs_t.delete();
        s_valid[0] = 1'b1;
        s_data[0 +: DW] = DW'(10);
        #1;
        n = 0;
        while (!s_ready[0] && n < 50) begin tick(); n++; end
        tick();
        s_valid[0] = 1'b0;
        lat = 1;
        while (!m_valid && lat < 50) begin tick(); lat++; end
        check("latency", lat, 9);
        for (int i = 1; i < 5; i++) send(0, 10 * (i + 1));
        drain();
        for (int i = 0; i < 5; i++) check("t1_result", at_d(i), t1[i]);
        check("t1_accept_interval", (hs_t.size() > 2) ? hs_t[2] - hs_t[1] : -1, 100);

        // Channel histories stay separate
        do_reset();
        load_box();
        out_d.delete(); out_c.delete();
        send(0, 10);
        send(1, 100);
        send(0, 20);
        drain();
        check("t2_r0", at_d(0), 10);
        check("t2_r1", at_d(1), 100);
        check("t2_r2", at_d(2), 30);
        check("t2_c1", at_c(1), 1);
        check("t2_c2", at_c(2), 0);

        // All channels requesting: round-robin order
        do_reset();
        load_box();
        grant_q.delete(); out_c.delete();
        s_data = {16'd4, 16'd3, 16'd2, 16'd1};
        s_valid = 4'hF;
        n = 0;
        while (grant_q.size() < 5 && n < 200) begin tick(); n++; end
        s_valid = '0;
        drain();
        for (int i = 0; i < 5; i++) begin
            check("t3_grant", (i < grant_q.size()) ? grant_q[i] : -1, g3[i]);
            check("t3_m_ch", at_c(i), g3[i]);
        end

        // Signed extremes
        do_reset();
        out_d.delete();
        write_coef(0, -1);
        send(2, -32768);
        drain();
        check("t4_neg_coef", at_d(0), 32768);
        write_coef(0, 32767);
        write_coef(1, 32767);
        send(2, -32768);
        send(2, -32768);
        drain();
        check("t4_max_product", at_d(2), -2147418112);

        // Output back-pressure
        m_ready = 1'b0;
        send(1, 7);
        n = 0;
        while (!m_valid && n < 50) begin tick(); n++; end
        s_valid[3] = 1'b1;
        s_data[3*DW +: DW] = DW'(5);
        for (int i = 0; i < 5; i++) begin
            check("t5_m_valid", m_valid, 1);
            check("t5_m_data", longint'($signed(m_data)), 229369);
            check("t5_m_ch", m_ch, 1);
            check("t5_s_ready", s_ready, 0);
            check("t5_busy", busy, 1);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("t5_next_grant", s_ready, 4'b1000);
        tick();
        s_valid[3] = 1'b0;
        drain();

        // Reset in the middle of MAC drops the result and history
        send(0, 10);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_m_data", m_data, 0);
        check("t6_m_ch", m_ch, 0);
        check("t6_busy", busy, 0);
        lat = 0;
        for (int i = 0; i < 15; i++) begin
            if (m_valid) lat++;
            tick();
        end
        check("t6_no_valid", lat, 0);
        load_box();
        out_d.delete();
        send(0, 10);
        drain();
        check("t6_refeed", at_d(0), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-multiplexes one serial multiply-accumulate FIR engine across NUM_CH independent sample channels. Each channel keeps its own delay line, and all channels share one programmable coefficient set. A round-robin arbiter picks which channel's sample is processed next. A sequencing FSM steps the MAC across the taps and presents each result with its channel tag on a valid/ready output. It sits between the multi-channel sample sources and the downstream filtered-data consumers, replacing one parallel fir_filter instance per channel.

Parameters:
NUM_CH, 4, number of input channels (power of two, >=2)
TAPS, 8, filter length (power of two, >=2)
DW, 16, signed input sample width
CW, 16, signed coefficient width
OW, 32, signed accumulator/output width (OW >= DW+CW)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  NUM_CH  per-channel sample valid
s_data  input  NUM_CH*DW  per-channel signed samples; channel i at bits [i*DW +: DW]
s_ready  output  NUM_CH  per-channel accept; one-hot or zero
coef_we  input  1  coefficient write strobe
coef_addr  input  log2(TAPS)  coefficient index
coef_data  input  CW  signed coefficient value
m_valid  output  1  result valid
m_data  output  OW  signed filter result
m_ch  output  log2(NUM_CH)  channel of m_data
m_ready  input  1  downstream accept
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - All delay lines are cleared to 0.
  - All coefficients are cleared to 0.
  - The round-robin pointer is set so that channel 0 has first priority.
  - FSM goes to IDLE.
  - Reset asserted mid-operation discards any in-flight or pending result. It clears all delay-line history, and no m_valid follows.
- FSM states: IDLE -> MAC -> OUT -> IDLE.
- IDLE:
  - The arbiter grants the first channel with s_valid=1, searching from (last_grant+1) mod NUM_CH.
  - s_ready is combinational and equals the one-hot grant. It is asserted only in IDLE and only for a valid channel.
  - Handshake happens at the edge where s_valid[g]&s_ready[g]=1. On that edge:
    - channel g's delay line shifts (hist[g][0] <= sample, hist[g][k] <= hist[g][k-1]);
    - acc <= 0, tap index k <= 0, ch_reg <= g, last_grant <= g;
    - next state is MAC.
  - With no s_valid asserted, the FSM stays in IDLE and last_grant is unchanged.
- MAC:
  - Exactly TAPS cycles. Each cycle: acc <= acc + sext(coef[k]*hist[ch_reg][k]); k <= k+1.
  - The product is a full signed DW+CW-bit value, sign-extended to OW.
  - Accumulation wraps modulo 2^OW; there is no saturation.
  - On the last tap, m_data <= final sum, m_ch <= ch_reg, m_valid <= 1, next state is OUT.
- OUT:
  - m_valid, m_data and m_ch are held stable until m_ready=1.
  - On the handshake edge, m_valid <= 0 and the FSM returns to IDLE.
  - m_data keeps its last value after the handshake.
- Timing (TAPS=8):
  - Input handshake at edge t gives m_valid high from cycle t+TAPS+1.
  - With m_ready held high, one sample is accepted every TAPS+2 cycles.
- Coefficient writes:
  - Accepted in any state and take effect at the edge where coef_we=1.
  - During MAC, taps already accumulated are unaffected. Taps read after the write use the new value.
  - A write in the same cycle as reset is ignored.
- Channel isolation: only the granted channel's delay line shifts. Samples offered on other channels are not consumed (their s_ready stays 0) and must be held by the source.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness guarantee: a continuously valid channel is granted within NUM_CH consecutive accepts.

Test Plan:
1. Write coef[0..3]=1, coef[4..7]=0, then feed ch0 with 10,20,30,40,50 (m_ready=1) -> m_data = 10,30,60,100,140, all with m_ch=0. The first m_valid appears 9 cycles after the s_ready handshake.
2. Same coefficients; ch0 gets 10, then ch1 gets 100, then ch0 gets 20 -> results (ch0,10), (ch1,100), (ch0,30). This confirms channel histories do not mix.
3. After reset, hold s_valid=4'b1111 continuously with samples 1,2,3,4 -> grant order ch0,1,2,3,0 and s_ready strictly one-hot. Each result's m_ch matches the grant order.
4. Set coef[0]=-1, feed ch2 with -32768 -> m_data=32768. Set coef[0]=32767, coef[1]=32767, feed -32768 twice -> second result is -2147418112, exactly, with no wrap.
5. Hold m_ready=0 for 5 cycles after m_valid rises -> m_data and m_ch stay stable, s_ready stays 0 and busy stays 1. Raising m_ready completes the transfer, and the next grant appears in the following IDLE cycle.
6. Assert rst for 1 cycle during MAC cycle 4 -> no m_valid follows and all outputs are 0. Re-feeding ch0 with 10 after reloading the coefficients gives 10, proving history was cleared.
